// File: rtl/pio_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pio_bus_pkg : shared types and defaults for the PIO register-bus master
// Rev 1.0
// ---------------------------------------------------------------------------
package pio_bus_pkg;

  localparam logic [11:0] c_max_addr_default = 12'h143;
  localparam int          c_timeout_default  = 16;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_SET   = 2'b10,
    OP_CLR   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RD_CAP = 3'd3,
    MOD_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  function automatic logic [31:0] apply_mask(input op_e op, input logic [31:0] old,
                                             input logic [31:0] mask);
    return (op == OP_CLR) ? (old & ~mask) : (old | mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timeout_ctr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_timeout_ctr : counts consecutive busy cycles of one bus transfer
// Rev 1.0
// ---------------------------------------------------------------------------
module bus_timeout_ctr
  import pio_bus_pkg::*;
#(
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_active,
  input  logic i_busy,
  output logic o_expired
);

  localparam int c_cw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [c_cw-1:0] r_count;

  // Fires on the TIMEOUT-th consecutive busy edge; the count never needs to hold TIMEOUT.
  assign o_expired = i_active && i_busy && (r_count == c_cw'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (!i_active || !i_busy || o_expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_cw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pio_reg_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pio_reg_master : command/response front end driving a sel/RW register bus,
//                  with read-modify-write SET/CLR and busy timeout
// Rev 1.0
// ---------------------------------------------------------------------------
module pio_reg_master
  import pio_bus_pkg::*;
#(
  parameter logic [11:0] MAX_ADDR = c_max_addr_default,
  parameter int          TIMEOUT  = c_timeout_default
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        sel,
  output logic        RW,
  output logic [11:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        busy
);

  state_e      r_state;
  state_e      w_next;
  op_e         r_op;
  logic [31:0] r_mask;
  logic        r_rw;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic        w_accept;
  logic        w_addr_ok;
  logic        w_bus_state;
  logic        w_expired;
  op_e         w_cmd_op;

  assign w_cmd_op    = op_e'(cmd_op);
  assign w_accept    = cmd_valid && (r_state == IDLE);
  assign w_addr_ok   = (cmd_addr <= MAX_ADDR);
  assign w_bus_state = (r_state == WR) || (r_state == RD) || (r_state == MOD_WR);

  assign RW       = r_rw;
  assign addr     = r_addr;
  assign wdata    = r_wdata;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_active  (w_bus_state),
    .i_busy    (busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    sel       = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!w_addr_ok)                w_next = RESP;
          else if (w_cmd_op == OP_WRITE) w_next = WR;
          else                           w_next = RD;
        end
      end
      WR, MOD_WR: begin
        sel = 1'b1;
        if (!busy || w_expired) w_next = RESP;
      end
      RD: begin
        sel = 1'b1;
        if (!busy)          w_next = RD_CAP;
        else if (w_expired) w_next = RESP;
      end
      RD_CAP: begin
        w_next = ((r_op == OP_SET) || (r_op == OP_CLR)) ? MOD_WR : RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus-side registers only change when a new transfer is set up, so they
  // naturally hold their last values whenever sel is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= OP_WRITE;
      r_mask     <= '0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= w_cmd_op;
        r_mask     <= cmd_data;
        r_rsp_data <= '0;
        r_rsp_err  <= !w_addr_ok;
        if (w_addr_ok) begin
          r_addr <= cmd_addr;
          r_rw   <= (w_cmd_op == OP_WRITE);
          if (w_cmd_op == OP_WRITE) r_wdata <= cmd_data;
        end
      end
      if (w_expired) begin
        r_rsp_err <= 1'b1;
      end
      if (r_state == RD_CAP) begin
        r_rsp_data <= rdata;
        if ((r_op == OP_SET) || (r_op == OP_CLR)) begin
          r_rw    <= 1'b1;
          r_wdata <= apply_mask(r_op, rdata, r_mask);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_reg_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pio_reg_master : directed bench with a transaction-level expectation model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pio_reg_master;
  import pio_bus_pkg::*;

  localparam logic [11:0] c_max = 12'h143;
  localparam int          c_to  = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        sel;
  logic        RW;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata = '0;
  logic        busy = 1'b0;

  pio_reg_master #(
    .MAX_ADDR (c_max),
    .TIMEOUT  (c_to)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .sel       (sel),
    .RW        (RW),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One expected cycle of DUT behaviour, plus the busy/rsp_ready to drive in it.
  typedef struct {
    logic        sel;
    logic        rw;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        busy;
    logic        rdy;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] ref_mem [0:4095];
  logic [31:0] tgt_mem [0:4095];
  logic        m_rw = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        id_rw = 1'b0;
  logic [11:0] id_addr = '0;
  logic [31:0] id_wdata = '0;
  int          neg_cnt = 0;
  int          acc_neg = 0;
  int          rise_neg = -1;
  int          sel_cnt = 0;
  logic        prev_rv = 1'b0;
  logic [31:0] last_rsp = '0;
  logic        last_err = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h1234_5678;
      'h0C8:   return 32'h0001_0000;
      'h020:   return 32'hA5A5_0000;
      default: return 32'hC0DE_0000 + 32'(i);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Register target: samples the bus just before each edge, answers just after.
  initial begin
    logic        t_rd, t_wr;
    logic [11:0] t_a;
    logic [31:0] t_d;
    for (int i = 0; i < 4096; i++) tgt_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      #4;
      t_rd = sel && !busy && !RW;
      t_wr = sel && !busy && RW;
      t_a  = addr;
      t_d  = wdata;
      @(posedge clk);
      #1;
      rdata = t_rd ? tgt_mem[t_a] : $urandom;
      if (t_wr) tgt_mem[t_a] = t_d;
    end
  end

  // Compare process: every cycle is either an expected transaction cycle or idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cmd_ready", cmd_ready, 0);
        chk("sel", sel, e.sel);
        chk("RW", RW, e.rw);
        chk("addr", addr, e.addr);
        chk("wdata", wdata, e.wdata);
        chk("rsp_valid", rsp_valid, e.rv);
        if (e.rv) begin
          chk("rsp_data", rsp_data, e.rd);
          chk("rsp_err", rsp_err, e.err);
        end
        busy      = e.busy;
        rsp_ready = e.rdy;
        id_rw     = e.rw;
        id_addr   = e.addr;
        id_wdata  = e.wdata;
      end else begin
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_sel", sel, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_RW", RW, id_rw);
        chk("idle_addr", addr, id_addr);
        chk("idle_wdata", wdata, id_wdata);
        busy      = 1'b0;
        rsp_ready = 1'b0;
      end
      if (sel) sel_cnt++;
      if (rsp_valid && !prev_rv) rise_neg = neg_cnt;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        last_rsp = rsp_data;
        last_err = rsp_err;
      end
    end
  end

  task automatic push(input logic s, input logic b, input logic rv, input logic rdy,
                      input logic [31:0] d, input logic er);
    exp_t e;
    e.sel = s;  e.rw = m_rw;  e.addr = m_addr;  e.wdata = m_wdata;
    e.rv = rv;  e.rd = d;     e.err = er;       e.busy = b;  e.rdy = rdy;
    q.push_back(e);
  endtask

  // One bus transfer stalled for nb cycles; gives up after c_to busy cycles.
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] wd,
                      input int nb, output logic to);
    m_rw = w;
    m_addr = a;
    if (w) m_wdata = wd;
    if (nb >= c_to) begin
      for (int i = 0; i < c_to; i++) push(1, 1, 0, 1, 0, 0);
      to = 1'b1;
    end else begin
      for (int i = 0; i < nb; i++) push(1, 1, 0, 1, 0, 0);
      push(1, 0, 0, 1, 0, 0);
      to = 1'b0;
    end
  endtask

  task automatic send(input op_e op, input logic [11:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 12'($urandom);
    cmd_data  = $urandom;
    acc_neg   = neg_cnt;
    rise_neg  = -1;
    sel_cnt   = 0;
  endtask

  task automatic do_cmd(input op_e op, input logic [11:0] a, input logic [31:0] d,
                        input int nb1, input int nb2, input int wt);
    logic [31:0] rd, old, nv;
    logic        er, to;
    int          n;
    send(op, a, d);
    rd = '0;
    er = 1'b0;
    to = 1'b0;
    if (a > c_max) begin
      er = 1'b1;
    end else begin
      case (op)
        OP_WRITE: begin
          xfer(1'b1, a, d, nb1, to);
          if (!to) ref_mem[a] = d;
        end
        OP_READ: begin
          xfer(1'b0, a, '0, nb1, to);
          if (!to) begin
            push(0, 0, 0, 1, 0, 0);
            rd = ref_mem[a];
          end
        end
        default: begin
          xfer(1'b0, a, '0, nb1, to);
          if (!to) begin
            push(0, 0, 0, 1, 0, 0);
            old = ref_mem[a];
            nv  = (op == OP_SET) ? (old | d) : (old & ~d);
            xfer(1'b1, a, nv, nb2, to);
            rd = old;
            if (!to) ref_mem[a] = nv;
          end
        end
      endcase
      er = to;
    end
    for (int i = 0; i <= wt; i++) push(0, 0, 1, (i == wt), rd, er);
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected cycles left, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_sel", sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_RW", RW, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    do_cmd(OP_WRITE, 12'h0CC, 32'hDEAD_BEEF, 0, 0, 0);
    chk("wr_latency", 32'(rise_neg - acc_neg), 2);
    chk("wr_sel_cycles", 32'(sel_cnt), 1);
    chk("wr_err", last_err, 0);
    chk("wr_mem", tgt_mem[12'h0CC], 32'hDEAD_BEEF);

    do_cmd(OP_READ, 12'h000, 32'h0, 0, 0, 0);
    chk("rd_latency", 32'(rise_neg - acc_neg), 3);
    chk("rd_data", last_rsp, 32'h1234_5678);

    do_cmd(OP_SET, 12'h0C8, 32'h0000_F000, 0, 0, 1);
    chk("set_latency", 32'(rise_neg - acc_neg), 4);
    chk("set_old", last_rsp, 32'h0001_0000);
    chk("set_mem", tgt_mem[12'h0C8], 32'h0001_F000);

    do_cmd(OP_CLR, 12'h0C8, 32'h0001_0000, 2, 3, 2);
    chk("clr_latency", 32'(rise_neg - acc_neg), 9);
    chk("clr_old", last_rsp, 32'h0001_F000);
    chk("clr_mem", tgt_mem[12'h0C8], 32'h0000_F000);

    do_cmd(OP_READ, 12'h0CC, 32'h0, 5, 0, 3);
    chk("rd_busy_data", last_rsp, 32'hDEAD_BEEF);

    do_cmd(OP_WRITE, 12'h0CC, 32'h1111_2222, 20, 0, 0);
    chk("wr_to_sel_cycles", 32'(sel_cnt), 16);
    chk("wr_to_latency", 32'(rise_neg - acc_neg), 17);
    chk("wr_to_err", last_err, 1);
    chk("wr_to_mem", tgt_mem[12'h0CC], 32'hDEAD_BEEF);

    do_cmd(OP_WRITE, 12'h143, 32'h0BAD_CAFE, 15, 0, 0);
    chk("wr_max_sel_cycles", 32'(sel_cnt), 16);
    chk("wr_max_err", last_err, 0);
    chk("wr_max_mem", tgt_mem[12'h143], 32'h0BAD_CAFE);

    do_cmd(OP_READ, 12'h144, 32'h0, 0, 0, 0);
    chk("oor_latency", 32'(rise_neg - acc_neg), 1);
    chk("oor_sel_cycles", 32'(sel_cnt), 0);
    chk("oor_err", last_err, 1);

    do_cmd(OP_READ, 12'h200, 32'h0, 0, 0, 1);
    chk("oor200_sel_cycles", 32'(sel_cnt), 0);
    chk("oor200_err", last_err, 1);

    do_cmd(OP_READ, 12'h005, 32'h0, 16, 0, 0);
    chk("rd_to_err", last_err, 1);
    chk("rd_to_data", last_rsp, 32'h0);

    do_cmd(OP_SET, 12'h010, 32'h0000_00FF, 0, 16, 0);
    chk("modwr_to_err", last_err, 1);
    chk("modwr_to_old", last_rsp, 32'hC0DE_0010);
    chk("modwr_to_mem", tgt_mem[12'h010], 32'hC0DE_0010);

    // SET interrupted by reset while its write is stalled
    send(OP_SET, 12'h020, 32'h0000_00FF);
    m_rw   = 1'b0;
    m_addr = 12'h020;
    push(1, 0, 0, 1, 0, 0);
    push(0, 0, 0, 1, 0, 0);
    m_rw    = 1'b1;
    m_wdata = 32'hA5A5_00FF;
    for (int i = 0; i < 6; i++) push(1, 1, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("modwr_sel", sel, 1);
    chk("modwr_wdata", wdata, 32'hA5A5_00FF);
    reset_n = 1'b0;
    q.delete();
    m_rw = 1'b0;  m_addr = '0;  m_wdata = '0;
    id_rw = 1'b0; id_addr = '0; id_wdata = '0;
    #1;
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_wdata", wdata, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("mid_rst_mem", tgt_mem[12'h020], 32'hA5A5_0000);

    do_cmd(OP_WRITE, 12'h020, 32'h600D_F00D, 1, 0, 0);
    do_cmd(OP_READ, 12'h020, 32'h0, 0, 0, 0);
    chk("post_rst_rd", last_rsp, 32'h600D_F00D);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pio_reg_master.md
PIO_REG_MASTER -- requirements
Module: pio_reg_master

Interface
REQ-001 SHALL provide parameter MAX_ADDR, default 12'h143, highest legal word address.
REQ-002 SHALL provide parameter TIMEOUT, default 16, maximum consecutive busy-high cycles per bus transfer.
REQ-003 SHALL provide port clk  in  1  single clock, rising edge.
REQ-004 SHALL provide port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port cmd_valid  in  1  command request.
REQ-006 SHALL provide port cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at a clk edge.
REQ-007 SHALL provide port cmd_op  in  2  00 WRITE, 01 READ, 10 SET bits, 11 CLR bits.
REQ-008 SHALL provide port cmd_addr  in  12  target word address.
REQ-009 SHALL provide port cmd_data  in  32  write data (WRITE) or bit mask (SET/CLR).
REQ-010 SHALL provide port rsp_valid  out  1  response available.
REQ-011 SHALL provide port rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high at a clk edge.
REQ-012 SHALL provide port rsp_data  out  32  read value (READ) or pre-modify value (SET/CLR); 0 for WRITE.
REQ-013 SHALL provide port rsp_err  out  1  address out of range or bus timeout.
REQ-014 SHALL provide port sel  out  1  register bus select.
REQ-015 SHALL provide port RW  out  1  1 = write, 0 = read.
REQ-016 SHALL provide port addr  out  12  register bus address.
REQ-017 SHALL provide port wdata  out  32  register bus write data.
REQ-018 SHALL provide port rdata  in  32  register bus read data, valid the cycle after a completed read.
REQ-019 SHALL provide port busy  in  1  target stall.

Function
REQ-020 SHALL implement FSM states IDLE, WR, RD, RD_CAP, MOD_WR, RESP; cmd_ready = (state == IDLE).
REQ-021 SHALL latch op, address and data on acceptance; accepted cmd_addr > MAX_ADDR -> RESP with rsp_err=1, rsp_data=0, no bus activity.
REQ-022 SHALL complete a bus transfer at a clk edge where sel=1 and busy=0; while busy=1, sel, RW, addr and wdata hold stable.
REQ-023 WRITE: IDLE -> WR (sel=1, RW=1, wdata=cmd_data) -> RESP; with busy=0, rsp_valid rises 2 cycles after acceptance.
REQ-024 READ: IDLE -> RD (sel=1, RW=0) -> RD_CAP (sel=0, capture rdata at its closing edge) -> RESP; with busy=0, rsp_valid rises 3 cycles after acceptance.
REQ-025 SET/CLR: RD -> RD_CAP -> MOD_WR (sel=1, RW=1, wdata = old|mask or old&~mask) -> RESP; rsp_data = old value; 4 cycles with busy=0.
REQ-026 SHALL count consecutive busy-high cycles in WR/RD/MOD_WR, clearing the count on each completed transfer; when the count reaches TIMEOUT, deassert sel and enter RESP with rsp_err=1 (a SET/CLR timed out in MOD_WR returns the captured old value).
REQ-027 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until rsp_ready; the handshake returns to IDLE, making cmd_ready=1 the next cycle (no same-cycle accept).
REQ-028 SHALL drive sel=0 in IDLE, RD_CAP and RESP; RW, addr and wdata retain their last values when sel=0.

Reset
REQ-029 reset_n low SHALL immediately force state=IDLE, sel=0, RW=0, addr=0, wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0, timeout count=0, cmd_ready=1, regardless of any in-flight transfer.
REQ-030 A transaction interrupted by reset SHALL be dropped with no response.

Structure
REQ-031 Package pio_bus_pkg SHALL hold the op enum, the state enum and the MAX_ADDR/TIMEOUT default constants.
REQ-032 No sub-module is required; the busy-timeout counter MAY be split out as bus_timeout_ctr.

Verification
REQ-033 WRITE 0x0CC, data 0xDEADBEEF, busy=0 -> one sel/RW=1 cycle with addr 0x0CC; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-034 READ 0x000 with rdata=0x12345678 -> rsp_data=0x12345678 after 3 cycles.
REQ-035 SET 0x0C8, mask 0x0000F000, old 0x00010000 -> write 0x0001F000; rsp_data=0x00010000.
REQ-036 busy held high for 20 cycles during WRITE, TIMEOUT=16 -> sel drops after 16 busy cycles; rsp_err=1.
REQ-037 READ 0x200 -> no sel pulse; rsp_err=1; then reset_n pulsed during SET MOD_WR -> sel=0 and rsp_valid=0 immediately; cmd_ready=1.
